// File: rtl/dense_controller.sv
// Sequencing FSM for the dense-layer datapath: clear, input load, MAC (+bias), output drain.
// Define DENSE_CTRL_BIAS_EN to give each output its own BIAS cycle; otherwise bias is skipped.
module dense_controller #(
    parameter int IN_COUNT  = 784,
    parameter int OUT_COUNT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inValid,
    input  logic outReady,
    input  logic gotData,
    input  logic mulDone,
    input  logic calcDone,
    input  logic putData,
    output logic clear,
    output logic busy,
    output logic rdi,
    output logic wri,
    output logic rdo,
    output logic wro,
    output logic inCntEn,
    output logic outCntEn,
    output logic clearReg,
    output logic WorB,
    output logic load,
    output logic inReady,
    output logic outValid,
    output logic done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLR      = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] MAC_INIT = 3'd3;
    localparam logic [2:0] MAC      = 3'd4;
    localparam logic [2:0] OUT      = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
`ifdef DENSE_CTRL_BIAS_EN
    localparam logic [2:0] BIAS     = 3'd7;
`endif

    // Illegal vector lengths keep the controller parked in IDLE.
    localparam bit CFG_OK = (IN_COUNT >= 2) && (OUT_COUNT >= 2);

    logic [2:0] state;
    logic [2:0] state_next;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        busy       = 1'b0;
        rdi        = 1'b0;
        wri        = 1'b0;
        rdo        = 1'b0;
        wro        = 1'b0;
        inCntEn    = 1'b0;
        outCntEn   = 1'b0;
        clearReg   = 1'b0;
        WorB       = 1'b0;
        load       = 1'b0;
        inReady    = 1'b0;
        outValid   = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start && CFG_OK)
                    state_next = CLR;
            end
            CLR: begin
                clear      = 1'b1;
                busy       = 1'b1;
                state_next = LOAD;
            end
            // Only the handshake-qualified strobes depend on inputs here.
            LOAD: begin
                busy    = 1'b1;
                inReady = 1'b1;
                if (inValid) begin
                    wri     = 1'b1;
                    inCntEn = 1'b1;
                    if (gotData)
                        state_next = MAC_INIT;
                end
            end
            MAC_INIT: begin
                busy       = 1'b1;
                clearReg   = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                busy    = 1'b1;
                rdi     = 1'b1;
                load    = 1'b1;
                inCntEn = 1'b1;
                if (mulDone) begin
`ifdef DENSE_CTRL_BIAS_EN
                    state_next = BIAS;
`else
                    // Without bias the final sum goes straight into the output RAM.
                    wro        = 1'b1;
                    outCntEn   = 1'b1;
                    state_next = calcDone ? OUT : MAC_INIT;
`endif
                end
            end
`ifdef DENSE_CTRL_BIAS_EN
            BIAS: begin
                busy       = 1'b1;
                WorB       = 1'b1;
                wro        = 1'b1;
                outCntEn   = 1'b1;
                state_next = calcDone ? OUT : MAC_INIT;
            end
`endif
            OUT: begin
                busy     = 1'b1;
                rdo      = 1'b1;
                outValid = 1'b1;
                if (outReady) begin
                    outCntEn = 1'b1;
                    if (putData)
                        state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dense_controller.sv
// Bench for dense_controller with a small counter model standing in for the datapath.
// Expectations follow DENSE_CTRL_BIAS_EN the same way the design does.
module tb_dense_controller;

    localparam int IN  = 4;
    localparam int OUT = 3;
`ifdef DENSE_CTRL_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif
    localparam int PER    = BIAS_ON ? IN + 2 : IN + 1;
    localparam int BASE   = 2 + IN + OUT * PER + OUT;
    localparam int BUDGET = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic inValid = 1'b0;
    logic outReady = 1'b0;
    logic gotData, mulDone, calcDone, putData;
    logic clear, busy, rdi, wri, rdo, wro, inCntEn, outCntEn;
    logic clearReg, WorB, load, inReady, outValid, done;
    logic [13:0] outs;

    int in_cnt = 0;
    int out_cnt = 0;

    int n_checks = 0;
    int n_pass = 0;

    int lat, n_wri, n_wro, n_acc, n_clr, n_worb, n_load, n_done, n_busy_tail;
    int wro_bad, run_bad, stall_bad, stall_seen;
    bit first_clear, rst_hit;
    logic [13:0] rst_outs;
    int lat_q[$];
    int idx_exp_q[$];
    int acc_q[$];

    dense_controller #(.IN_COUNT(IN), .OUT_COUNT(OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .inValid(inValid), .outReady(outReady),
        .gotData(gotData), .mulDone(mulDone), .calcDone(calcDone), .putData(putData),
        .clear(clear), .busy(busy), .rdi(rdi), .wri(wri), .rdo(rdo), .wro(wro),
        .inCntEn(inCntEn), .outCntEn(outCntEn), .clearReg(clearReg), .WorB(WorB),
        .load(load), .inReady(inReady), .outValid(outValid), .done(done)
    );

    always #5 clk = ~clk;

    assign outs = {clear, busy, rdi, wri, rdo, wro, inCntEn, outCntEn,
                   clearReg, WorB, load, inReady, outValid, done};

    // Datapath counters: wrap at N-1, zeroed by clear or rst.
    always @(posedge clk) begin
        if (rst || clear) begin
            in_cnt  <= 0;
            out_cnt <= 0;
        end else begin
            if (inCntEn)  in_cnt  <= (in_cnt == IN - 1) ? 0 : in_cnt + 1;
            if (outCntEn) out_cnt <= (out_cnt == OUT - 1) ? 0 : out_cnt + 1;
        end
    end

    assign gotData  = (in_cnt == IN - 1);
    assign mulDone  = (in_cnt == IN - 1);
    assign calcDone = (out_cnt == OUT - 1);
    assign putData  = (out_cnt == OUT - 1);

    // Drives one evaluation from the start edge and records what the DUT did.
    task automatic run_eval(input int in_mode, input int stall_word, input int stall_len,
                            input int rst_phase, input bit poke_start, input int tail);
        int n;
        bit fin;
        bit tgl;
        bit prev_clr;
        bit poked;
        int cur_run;
        int stall_left;
        lat = -1; n_wri = 0; n_wro = 0; n_acc = 0; n_clr = 0; n_worb = 0;
        n_load = 0; n_done = 0; n_busy_tail = 0; wro_bad = 0; run_bad = 0;
        stall_bad = 0; stall_seen = 0; first_clear = 1'b0; rst_hit = 1'b0;
        rst_outs = '1;
        acc_q.delete();
        n = 1; fin = 1'b0; tgl = 1'b0; prev_clr = 1'b0; poked = 1'b0;
        cur_run = 0; stall_left = stall_len;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        while (!fin && n < BUDGET) begin
            start = 1'b0;
            if (in_mode == 1) begin
                if (inReady) begin
                    inValid = tgl;
                    tgl = !tgl;
                end else begin
                    inValid = 1'b0;
                end
            end else begin
                inValid = 1'b1;
            end
            if (outValid && n_acc == stall_word && stall_left > 0) begin
                outReady = 1'b0;
                stall_left--;
            end else begin
                outReady = 1'b1;
            end
            #1;
            if (n == 1 && clear) first_clear = 1'b1;
            if (wri) n_wri++;
            if (wro) n_wro++;
            if (clearReg) n_clr++;
            if (WorB) n_worb++;
            if (inReady) n_load++;
            if (outValid && outReady) begin
                n_acc++;
                acc_q.push_back(out_cnt);
            end
            if (wro && (BIAS_ON ? !WorB : !mulDone)) wro_bad++;
            if (!outReady) begin
                stall_seen++;
                if (!outValid || outCntEn) stall_bad++;
            end
            if (load && !WorB) begin
                if (cur_run == 0 && !prev_clr) run_bad++;
                cur_run++;
            end else if (cur_run != 0) begin
                if (cur_run != IN) run_bad++;
                cur_run = 0;
            end
            prev_clr = clearReg;
            if (done) begin
                n_done++;
                lat = n;
                fin = 1'b1;
                if (poke_start) start = 1'b1;
            end
            if (poke_start && load && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (rst_phase > 0 && load && n_clr == rst_phase && !rst_hit) begin
                rst = 1'b1;
                rst_hit = 1'b1;
                @(negedge clk);
                #1;
                rst_outs = outs;
                rst = 1'b0;
                fin = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        for (int k = 0; k < tail; k++) begin
            start = 1'b0;
            #1;
            if (done) n_done++;
            if (busy) n_busy_tail++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        inValid = 1'b1;
        outReady = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs !== 14'd0) $display("[TB] FAIL reset_outs: got %b expected 0", outs);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (outs !== 14'd0) $display("[TB] FAIL idle_outs cycle %0d: got %b expected 0", k, outs);
            else n_pass++;
        end
    endtask

    task automatic test_full_run();
        int e;
        int o;
        lat_q.push_back(BASE);
        for (int i = 0; i < OUT; i++) idx_exp_q.push_back(i);
        run_eval(0, -1, 0, 0, 1'b0, 0);
        e = lat_q.pop_front();
        n_checks++;
        if (lat !== e) $display("[TB] FAIL full_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (first_clear !== 1'b1) $display("[TB] FAIL clr_cycle1: got %0d expected 1", first_clear);
        else n_pass++;
        n_checks++;
        if (n_wri !== IN) $display("[TB] FAIL full_wri: got %0d expected %0d", n_wri, IN);
        else n_pass++;
        n_checks++;
        if (n_wro !== OUT) $display("[TB] FAIL full_wro: got %0d expected %0d", n_wro, OUT);
        else n_pass++;
        n_checks++;
        if (n_acc !== OUT) $display("[TB] FAIL full_accepted: got %0d expected %0d", n_acc, OUT);
        else n_pass++;
        n_checks++;
        if (n_clr !== OUT) $display("[TB] FAIL full_clearReg: got %0d expected %0d", n_clr, OUT);
        else n_pass++;
        n_checks++;
        if (run_bad !== 0) $display("[TB] FAIL mac_runs: got %0d bad runs expected 0", run_bad);
        else n_pass++;
        n_checks++;
        if (n_worb !== (BIAS_ON ? OUT : 0))
            $display("[TB] FAIL worb_count: got %0d expected %0d", n_worb, BIAS_ON ? OUT : 0);
        else n_pass++;
        n_checks++;
        if (wro_bad !== 0) $display("[TB] FAIL wro_timing: got %0d misplaced expected 0", wro_bad);
        else n_pass++;
        n_checks++;
        if (n_load !== IN) $display("[TB] FAIL load_len: got %0d expected %0d", n_load, IN);
        else n_pass++;
        n_checks++;
        if (n_done !== 1) $display("[TB] FAIL full_done_count: got %0d expected 1", n_done);
        else n_pass++;
        while (idx_exp_q.size() != 0) begin
            e = idx_exp_q.pop_front();
            o = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
            n_checks++;
            if (o !== e) $display("[TB] FAIL out_index: got %0d expected %0d", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_input_stall();
        int e;
        lat_q.push_back(BASE + IN);
        run_eval(1, -1, 0, 0, 1'b0, 0);
        e = lat_q.pop_front();
        n_checks++;
        if (lat !== e) $display("[TB] FAIL install_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (n_wri !== IN) $display("[TB] FAIL install_wri: got %0d expected %0d", n_wri, IN);
        else n_pass++;
        n_checks++;
        if (n_load !== 2 * IN) $display("[TB] FAIL install_load_len: got %0d expected %0d", n_load, 2 * IN);
        else n_pass++;
    endtask

    task automatic test_output_backpressure();
        int e;
        lat_q.push_back(BASE + 5);
        run_eval(0, 1, 5, 0, 1'b0, 0);
        e = lat_q.pop_front();
        n_checks++;
        if (lat !== e) $display("[TB] FAIL backpressure_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (stall_seen !== 5) $display("[TB] FAIL stall_cycles: got %0d expected 5", stall_seen);
        else n_pass++;
        n_checks++;
        if (stall_bad !== 0) $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", stall_bad);
        else n_pass++;
        n_checks++;
        if (n_acc !== OUT) $display("[TB] FAIL backpressure_accepted: got %0d expected %0d", n_acc, OUT);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        run_eval(0, -1, 0, 2, 1'b0, 0);
        n_checks++;
        if (rst_hit !== 1'b1) $display("[TB] FAIL mid_reset_reached: got %0d expected 1", rst_hit);
        else n_pass++;
        n_checks++;
        if (rst_outs !== 14'd0) $display("[TB] FAIL mid_reset_outs: got %b expected 0", rst_outs);
        else n_pass++;
        n_checks++;
        if (n_done !== 0) $display("[TB] FAIL mid_reset_done: got %0d expected 0", n_done);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int e;
        lat_q.push_back(BASE);
        run_eval(0, -1, 0, 0, 1'b1, 20);
        e = lat_q.pop_front();
        n_checks++;
        if (lat !== e) $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (n_done !== 1) $display("[TB] FAIL busy_start_done_count: got %0d expected 1", n_done);
        else n_pass++;
        n_checks++;
        if (n_busy_tail !== 0) $display("[TB] FAIL restart_from_done: got %0d busy cycles expected 0", n_busy_tail);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_input_stall();
        test_output_backpressure();
        test_mid_reset();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
